test_frame_checker: RTL and testbench
=====================================

Name: test_frame_checker

Overview:
- Receive-side counterpart of the test frame generator; one instance per port.
- Sinks the port's RX AXI-Stream (64-bit beats) and captures the 34-byte frame_header_t (Ethernet plus IPv4).
- Classifies each frame as non-test, good test or errored test, and accumulates the port's port_result_t counters for the register block.
- Counting is gated by the test-running window driven by the test controller.

Parameters:
- DATA_WIDTH, 64, AXI-Stream data width in bits; only 64 supported.
- KEEP_WIDTH, 8, DATA_WIDTH/8.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- s_tdata  in  64  RX frame data; frame byte n of a beat in bits [8n+7:8n].
- s_tkeep  in  8  byte enables; contiguous from bit 0.
- s_tlast  in  1  last beat of frame.
- s_tuser  in  1  MAC error flag; sampled on the tlast beat.
- s_tvalid  in  1  beat valid.
- s_tready  out  1  always 1 after reset; the block never back-pressures.
- cfg  in  $bits(port_config_t)  this port's configuration.
- count_en  in  1  test window active; frames are committed only while high.
- clear  in  1  one-cycle pulse from test start; zeroes all counters.
- result  out  $bits(port_result_t)  accumulated statistics.
- frame_done  out  1  one-cycle pulse per committed test frame (good or errored).

Behaviour:
- Reset: s_tready=0 during reset, then 1. result='0, frame_done=0, state HEADER, byte counter 0.
- Beat accepted when s_tvalid & s_tready.
- Header capture: bytes 0..33 land in a frame_header_t register using the same byte-to-bit mapping as s_tdata (byte n at bits [8n+7:8n]).
- FSM states:
  - HEADER: collect header bytes; moves to PAYLOAD when byte count ≥34 with no tlast yet.
  - PAYLOAD: accumulate the byte count only.
  - Any accepted tlast beat commits the frame and returns to HEADER.
- Frame byte count: 14-bit running sum of popcount(s_tkeep).
- Per-frame format error flag: set if a non-tlast beat has s_tkeep != 8'hFF.
- Classification at tlast:
  - Test frame: byte count ≥34, ether_type == 16'h0008 (0x0800 in byte order), version 4, tos 8'hDE, proto 8'hFD.
  - Otherwise the frame is non-test. It is ignored entirely: no counter change, no frame_done.
- A test frame is good iff all of:
  - s_tuser=0 on the tlast beat;
  - format error flag clear;
  - ihl 5;
  - captured checksum equals the recomputed checksum (ip_header_checksum instance over the captured header);
  - byte count == frame_size in cfg, and ip len field (byte-swapped) == byte count − 14;
  - dst_mac == cfg.src_mac and dst_ip == cfg.src_ip;
  - cfg.enable = 1.
- Good test frame: recv_frames += 1 and recv_bytes += byte count.
- Errored test frame (test frame, not good): err_frames += 1 and err_bytes += byte count.
- Commit latency: header checks are registered. Counters and frame_done update 2 cycles after the tlast beat is accepted, in a pipelined commit stage.
- Back-to-back frames: tlast in cycle N and the new frame's first beat in N+1 must be supported. The commit pipeline holds its own copy of the classification inputs, so capture of the next header does not corrupt it.
- count_en: sampled in the commit stage. If 0, the frame is classified but nothing is counted and frame_done stays 0.
- clear: zeroes all four counters in the next cycle. If clear coincides with a commit, clear wins and the commit is discarded. clear does not reset the FSM; a frame in flight is still classified normally.
- Arithmetic: all counters are 32-bit and wrap modulo 2^32; no saturation. A byte count above 8191 sets the format error flag, and the counter holds at 8191.
- reset_n asserted mid-frame: all state returns to reset values. The partial frame is lost and never counted. After release the block waits for the next beat, which it treats as byte 0; upstream guarantees frame-aligned restart.

Test Plan:
- Reset and idle: hold reset_n=0, then release → result=0, s_tready=1, frame_done never pulses with no traffic.
- Good frame: count_en=1, cfg frame_size=64, matching MAC/IP/checksum, 8 full beats → recv_frames=1, recv_bytes=64, err=0; frame_done pulses 2 cycles after tlast.
- Header errors: same frame with a corrupted checksum, then with s_tuser=1, then with a 60-byte length mismatch → err_frames=3, err_bytes=64+64+60, recv unchanged.
- Non-test traffic: ARP frame (ether_type 0x0806), IPv4 frame with tos 0x00, and a 20-byte runt → all counters unchanged, no frame_done.
- Streaming, clear and count_en: 1000 back-to-back good 64-byte frames → recv_frames=1000, recv_bytes=64000. Then a clear coinciding with a commit → all counters 0. Then a frame sent with count_en=0 → still 0.
- Wrap and reset: preload recv_bytes near 2^32−10 via repeated frames (or force), add one 64-byte frame → wraps to 54. Assert reset_n mid-frame → counters 0, and the next full frame counts as exactly 1.

Source files
------------

// File: rtl/frame_checker_pkg.sv
// Shared frame/statistics types for the test frame checker.
// Multi-byte header fields keep wire byte n at bits [8n+7:8n].
package frame_checker_pkg;

  typedef struct packed {
    logic [31:0] dst_ip;      // bytes 30..33
    logic [31:0] src_ip;      // bytes 26..29
    logic [15:0] checksum;    // bytes 24..25
    logic [7:0]  proto;       // byte 23
    logic [7:0]  ttl;         // byte 22
    logic [15:0] frag;        // bytes 20..21
    logic [15:0] id;          // bytes 18..19
    logic [15:0] len;         // bytes 16..17
    logic [7:0]  tos;         // byte 15
    logic [3:0]  version;     // byte 14 high nibble
    logic [3:0]  ihl;         // byte 14 low nibble
    logic [15:0] ether_type;  // bytes 12..13
    logic [47:0] src_mac;     // bytes 6..11
    logic [47:0] dst_mac;     // bytes 0..5
  } frame_header_t;

  typedef struct packed {
    logic        enable;
    logic [13:0] frame_size;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
  } port_config_t;

  typedef struct packed {
    logic [31:0] recv_frames;
    logic [31:0] recv_bytes;
    logic [31:0] err_frames;
    logic [31:0] err_bytes;
  } port_result_t;

endpackage

// File: rtl/ip_header_checksum.sv
// Combinational IPv4 header checksum over the 20 header bytes, ignoring the
// stored checksum word; result is returned in captured-field byte order.
module ip_header_checksum (
  input  logic [159:0] ip_bytes,
  output logic [15:0]  checksum
);

  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < 10; k++) begin
      if (k != 5)
        sum = sum + {4'd0, ip_bytes[16*k +: 8], ip_bytes[16*k+8 +: 8]};
    end
    fold1    = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
    fold2    = fold1[15:0] + {15'd0, fold1[16]};
    checksum = ~{fold2[7:0], fold2[15:8]};
  end

endmodule

// File: rtl/test_frame_checker.sv
// RX-side test frame checker: captures the Ethernet/IPv4 header, classifies
// each frame at tlast and accumulates per-port statistics.
module test_frame_checker
  import frame_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  port_config_t          cfg,
  input  logic                  count_en,
  input  logic                  clear,
  output port_result_t          result,
  output logic                  frame_done
);

  localparam logic [0:0]  ST_HEADER  = 1'b0;
  localparam logic [0:0]  ST_PAYLOAD = 1'b1;
  localparam int unsigned HDR_BYTES  = 34;
  localparam logic [13:0] MAX_BYTES  = 14'd8191;

  logic [0:0]    state;
  logic [13:0]   byte_cnt;
  logic          fmt_err;
  frame_header_t hdr;

  logic          beat;
  logic [3:0]    beat_bytes;
  logic [14:0]   cnt_sum;
  logic [13:0]   cnt_next;
  logic          err_next;
  frame_header_t hdr_next;

  // Commit-stage copy of the finished frame, independent of the next capture
  logic          p_valid;
  frame_header_t p_hdr;
  logic [13:0]   p_cnt;
  logic          p_err;
  logic          p_tuser;

  logic [15:0]   csum_calc;
  logic          is_test;
  logic          is_good;
  port_result_t  res_q;
  logic          unused_src_mac;

  assign beat = s_tvalid & s_tready;

  always_comb begin
    beat_bytes = '0;
    for (int unsigned i = 0; i < KEEP_WIDTH; i++)
      beat_bytes = beat_bytes + {3'd0, s_tkeep[i]};
    cnt_sum  = {1'b0, byte_cnt} + {11'd0, beat_bytes};
    err_next = fmt_err | (!s_tlast && (s_tkeep != '1)) | (cnt_sum > {1'b0, MAX_BYTES});
    cnt_next = (cnt_sum > {1'b0, MAX_BYTES}) ? MAX_BYTES : cnt_sum[13:0];
    hdr_next = hdr;
    if (state == ST_HEADER) begin
      for (int unsigned h = 0; h < HDR_BYTES; h++) begin
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
          if (s_tkeep[i] && ((32'(byte_cnt) + i) == h))
            hdr_next[8*h +: 8] = s_tdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HEADER;
      byte_cnt <= '0;
      fmt_err  <= 1'b0;
      hdr      <= '0;
      s_tready <= 1'b0;
      p_valid  <= 1'b0;
      p_hdr    <= '0;
      p_cnt    <= '0;
      p_err    <= 1'b0;
      p_tuser  <= 1'b0;
    end else begin
      s_tready <= 1'b1;
      p_valid  <= 1'b0;
      if (beat) begin
        hdr <= hdr_next;
        if (s_tlast) begin
          state    <= ST_HEADER;
          byte_cnt <= '0;
          fmt_err  <= 1'b0;
          p_valid  <= 1'b1;
          p_hdr    <= hdr_next;
          p_cnt    <= cnt_next;
          p_err    <= err_next;
          p_tuser  <= s_tuser;
        end else begin
          byte_cnt <= cnt_next;
          fmt_err  <= err_next;
          if (cnt_next >= 14'(HDR_BYTES))
            state <= ST_PAYLOAD;
        end
      end
    end
  end

  ip_header_checksum u_csum (
    .ip_bytes (p_hdr[271:112]),
    .checksum (csum_calc)
  );

  assign unused_src_mac = ^p_hdr.src_mac;

  always_comb begin
    is_test = (p_cnt >= 14'd34) && (p_hdr.ether_type == 16'h0008) &&
              (p_hdr.version == 4'd4) && (p_hdr.tos == 8'hDE) && (p_hdr.proto == 8'hFD);
    is_good = !p_tuser && !p_err && (p_hdr.ihl == 4'd5) &&
              (p_hdr.checksum == csum_calc) && (p_cnt == cfg.frame_size) &&
              ({p_hdr.len[7:0], p_hdr.len[15:8]} == ({2'b00, p_cnt} - 16'd14)) &&
              (p_hdr.dst_mac == cfg.src_mac) && (p_hdr.dst_ip == cfg.src_ip) && cfg.enable;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (clear) begin
        res_q <= '0;
      end else if (p_valid && is_test && count_en) begin
        frame_done <= 1'b1;
        if (is_good) begin
          res_q.recv_frames <= res_q.recv_frames + 32'd1;
          res_q.recv_bytes  <= res_q.recv_bytes + {18'd0, p_cnt};
        end else begin
          res_q.err_frames <= res_q.err_frames + 32'd1;
          res_q.err_bytes  <= res_q.err_bytes + {18'd0, p_cnt};
        end
      end
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_test_frame_checker.sv
// Self-checking bench: frame-level classification model plus per-cycle compare.
module tb_test_frame_checker;
  import frame_checker_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [63:0]  s_tdata = '0;
  logic [7:0]   s_tkeep = '0;
  logic         s_tlast = 1'b0;
  logic         s_tuser = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  port_config_t cfg;
  logic         count_en = 1'b0;
  logic         clear = 1'b0;
  port_result_t result;
  logic         frame_done;

  test_frame_checker #(.DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .cfg(cfg), .count_en(count_en), .clear(clear), .result(result),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic check_en = 1'b0;
  logic [7:0] fb [0:127];
  port_result_t preload;

  // Frame-level model state
  logic [31:0] m_rf = '0, m_rb = '0, m_ef = '0, m_eb = '0;
  logic        m_done = 1'b0;
  logic        cur_test = 1'b0, cur_good = 1'b0;
  int          cur_len = 0;
  logic        pend_v = 1'b0, pend_test = 1'b0, pend_good = 1'b0;
  int          pend_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [15:0] ones_sum(input logic skip_csum);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 10; k++)
      if (!(skip_csum && k == 5)) s = s + {16'd0, fb[14+2*k], fb[15+2*k]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return s[15:0];
  endfunction

  task automatic build(input int len, input logic [15:0] etype, input logic [7:0] tos,
                       input logic bad_csum);
    logic [15:0] c;
    for (int i = 0; i < 128; i++) fb[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 6; i++) fb[i] = cfg.src_mac[8*i +: 8];
    for (int i = 6; i < 12; i++) fb[i] = 8'(8'h20 + i);
    fb[12] = etype[15:8]; fb[13] = etype[7:0];
    fb[14] = 8'h45; fb[15] = tos;
    c = 16'(len - 14);
    fb[16] = c[15:8]; fb[17] = c[7:0];
    fb[18] = 8'h12; fb[19] = 8'h34; fb[20] = 8'h40; fb[21] = 8'h00;
    fb[22] = 8'd64; fb[23] = 8'hFD;
    fb[24] = 8'h00; fb[25] = 8'h00;
    fb[26] = 8'h0A; fb[27] = 8'h00; fb[28] = 8'h00; fb[29] = 8'h02;
    for (int i = 0; i < 4; i++) fb[30+i] = cfg.src_ip[8*i +: 8];
    c = ~ones_sum(1'b1);
    fb[24] = c[15:8]; fb[25] = c[7:0] ^ {7'd0, bad_csum};
  endtask

  task automatic classify(input int dlen, input logic tuser, input logic fmt);
    logic ok;
    cur_len  = dlen;
    cur_test = (dlen >= 34) && fb[12] == 8'h08 && fb[13] == 8'h00 &&
               fb[14][7:4] == 4'd4 && fb[15] == 8'hDE && fb[23] == 8'hFD;
    ok = !tuser && !fmt && fb[14][3:0] == 4'd5 && ones_sum(1'b0) == 16'hFFFF &&
         dlen == int'(cfg.frame_size) && {fb[16], fb[17]} == 16'(dlen - 14) && cfg.enable;
    for (int i = 0; i < 6; i++) if (fb[i] != cfg.src_mac[8*i +: 8]) ok = 1'b0;
    for (int i = 0; i < 4; i++) if (fb[30+i] != cfg.src_ip[8*i +: 8]) ok = 1'b0;
    cur_good = ok;
  endtask

  // Sends fb[0..len-1]; bad_beat delivers only 4 bytes of that beat; stop_beats truncates without tlast.
  task automatic send(input int len, input logic tuser, input int bad_beat, input int stop_beats);
    int nbeats;
    int n;
    nbeats = (len + 7) / 8;
    classify(len - ((bad_beat >= 0) ? 4 : 0), tuser, bad_beat >= 0);
    for (int b = 0; b < nbeats && b < stop_beats; b++) begin
      n = (len - 8*b >= 8) ? 8 : len - 8*b;
      if (b == bad_beat) n = 4;
      s_tdata = '0; s_tkeep = '0;
      for (int i = 0; i < n; i++) begin
        s_tdata[8*i +: 8] = fb[8*b+i];
        s_tkeep[i] = 1'b1;
      end
      s_tvalid = 1'b1;
      s_tlast  = (b == nbeats - 1);
      s_tuser  = s_tlast & tuser;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Committed frames take effect on the edge after the tlast edge
  always @(posedge clk) begin
    if (!reset_n) begin
      m_rf = '0; m_rb = '0; m_ef = '0; m_eb = '0; m_done = 1'b0; pend_v = 1'b0;
    end else begin
      m_done = 1'b0;
      if (clear) begin
        m_rf = '0; m_rb = '0; m_ef = '0; m_eb = '0;
      end else if (pend_v && pend_test && count_en) begin
        m_done = 1'b1;
        if (pend_good) begin m_rf = m_rf + 1; m_rb = m_rb + 32'(pend_len); end
        else           begin m_ef = m_ef + 1; m_eb = m_eb + 32'(pend_len); end
      end
      pend_v = s_tvalid && s_tlast;
      pend_test = cur_test; pend_good = cur_good; pend_len = cur_len;
    end
  end

  always @(negedge clk) begin
    if (reset_n && check_en) begin
      chk("s_tready", {31'd0, s_tready}, 32'd1);
      chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
      chk("recv_frames", result.recv_frames, m_rf);
      chk("recv_bytes", result.recv_bytes, m_rb);
      chk("err_frames", result.err_frames, m_ef);
      chk("err_bytes", result.err_bytes, m_eb);
    end
  end

  initial begin
    cfg = '{enable: 1'b1, frame_size: 14'd64, src_mac: 48'h665544332211, src_ip: 32'h0500A8C0};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tready", {31'd0, s_tready}, 32'd0);
    chk("reset_result", 32'(|result), 32'd0);
    chk("reset_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    check_en = 1'b1;
    count_en = 1'b1;
    idle(5);
    chk("idle_result", 32'(|result), 32'd0);

    build(64, 16'h0800, 8'hDE, 1'b0);
    send(64, 1'b0, -1, 99);
    chk("done_not_yet", {31'd0, frame_done}, 32'd0);
    idle(1);
    chk("done_pulse", {31'd0, frame_done}, 32'd1);
    idle(2);
    chk("good_rf", result.recv_frames, 32'd1);
    chk("good_rb", result.recv_bytes, 32'd64);
    chk("good_ef", result.err_frames, 32'd0);

    build(64, 16'h0800, 8'hDE, 1'b1); send(64, 1'b0, -1, 99);
    build(64, 16'h0800, 8'hDE, 1'b0); send(64, 1'b1, -1, 99);
    build(60, 16'h0800, 8'hDE, 1'b0); send(60, 1'b0, -1, 99);
    build(64, 16'h0800, 8'hDE, 1'b0); send(64, 1'b0, 5, 99);
    idle(3);
    chk("err_ef", result.err_frames, 32'd4);
    chk("err_eb", result.err_bytes, 32'd248);
    chk("err_rf", result.recv_frames, 32'd1);

    build(64, 16'h0806, 8'hDE, 1'b0); send(64, 1'b0, -1, 99);
    build(64, 16'h0800, 8'h00, 1'b0); send(64, 1'b0, -1, 99);
    build(20, 16'h0800, 8'hDE, 1'b0); send(20, 1'b0, -1, 99);
    idle(3);
    chk("nontest_rf", result.recv_frames, 32'd1);
    chk("nontest_rb", result.recv_bytes, 32'd64);
    chk("nontest_ef", result.err_frames, 32'd4);
    chk("nontest_eb", result.err_bytes, 32'd248);

    clear = 1'b1; idle(1); clear = 1'b0; idle(1);
    chk("clear_all", 32'(|result), 32'd0);
    build(64, 16'h0800, 8'hDE, 1'b0);
    repeat (1000) send(64, 1'b0, -1, 99);
    idle(3);
    chk("stream_rf", result.recv_frames, 32'd1000);
    chk("stream_rb", result.recv_bytes, 32'd64000);

    send(64, 1'b0, -1, 99);
    clear = 1'b1; idle(1); clear = 1'b0; idle(3);
    chk("clear_commit", 32'(|result), 32'd0);

    count_en = 1'b0;
    send(64, 1'b0, -1, 99);
    idle(3);
    count_en = 1'b1;
    chk("count_en_off", 32'(|result), 32'd0);

    preload = '{recv_frames: 32'd5, recv_bytes: 32'hFFFF_FFF6, err_frames: 32'd0, err_bytes: 32'd0};
    force dut.res_q = preload;
    m_rf = 32'd5; m_rb = 32'hFFFF_FFF6; m_ef = '0; m_eb = '0;
    #1;
    release dut.res_q;
    idle(1);
    send(64, 1'b0, -1, 99);
    idle(3);
    chk("wrap_rb", result.recv_bytes, 32'd54);
    chk("wrap_rf", result.recv_frames, 32'd6);

    send(64, 1'b0, -1, 4);
    check_en = 1'b0;
    reset_n = 1'b0;
    idle(1);
    chk("midreset_result", 32'(|result), 32'd0);
    chk("midreset_tready", {31'd0, s_tready}, 32'd0);
    idle(1);
    reset_n = 1'b1;
    idle(1);
    check_en = 1'b1;
    build(64, 16'h0800, 8'hDE, 1'b0);
    send(64, 1'b0, -1, 99);
    idle(3);
    chk("after_reset_rf", result.recv_frames, 32'd1);
    chk("after_reset_rb", result.recv_bytes, 32'd64);
    chk("after_reset_ef", result.err_frames, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
